// File: rtl/pktunit_axis_arbiter.sv
// Round-robin, packet-locked arbiter merging NUM_SRC packet-unit streams onto one sink.
// Optional per-source packet counters are enabled by defining PKTUNIT_ARB_PKT_CNT_EN.
module pktunit_axis_arbiter #(
   parameter int DATA_BYTES = 8,
   parameter int NUM_SRC    = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_SRC*DATA_BYTES*8-1:0]     s_data_d,
   input  logic [NUM_SRC-1:0]                  s_data_v,
   input  logic [NUM_SRC-1:0]                  s_flags_v,
   input  logic [NUM_SRC-1:0]                  s_eop_v,
   input  logic [NUM_SRC*8-1:0]                s_flags_d,
   input  logic [NUM_SRC*(DATA_BYTES+1)-1:0]   s_eop_d,
   output logic [NUM_SRC-1:0]                  s_data_r,
   output logic [NUM_SRC-1:0]                  s_flags_r,
   output logic [NUM_SRC-1:0]                  s_eop_r,
   output logic [DATA_BYTES*8-1:0]             m_data_d,
   output logic [7:0]                          m_flags_d,
   output logic [DATA_BYTES:0]                 m_eop_d,
   output logic                                m_data_v,
   output logic                                m_flags_v,
   output logic                                m_eop_v,
   input  logic                                m_data_r,
   input  logic                                m_flags_r,
   input  logic                                m_eop_r,
   output logic [1:0]                          grant,
   output logic                                busy,
   output logic [NUM_SRC*16-1:0]               pkt_cnt
);

   // state | meaning
   // IDLE  | no packet owned; arbitrate among joint-valid requesters
   // BUSY  | packet owned by source 'grant' until its eop beat transfers

   localparam int DW = DATA_BYTES * 8;
   localparam int EW = DATA_BYTES + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [1:0] last_grant;
   logic [1:0] nxt_grant;
   logic [2:0] cand;
   logic [3:0] req;
   logic       sink_rdy;
   logic       xfer;
   logic       eop_beat;

   assign req      = 4'(s_data_v & s_flags_v & s_eop_v);
   assign sink_rdy = m_data_r & m_flags_r & m_eop_r;
   assign xfer     = busy & req[grant] & sink_rdy;
   assign eop_beat = |m_eop_d;

   // Walk candidates from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      nxt_grant = '0;
      cand      = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand = {1'b0, last_grant} + 3'(k);
         if (cand >= 3'(NUM_SRC))
            cand = cand - 3'(NUM_SRC);
         if (req[cand[1:0]])
            nxt_grant = cand[1:0];
      end
   end

   always_comb begin
      m_data_d  = '0;
      m_flags_d = '0;
      m_eop_d   = '0;
      s_data_r  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (busy && grant == 2'(i)) begin
            m_data_d    = s_data_d[i*DW +: DW];
            m_flags_d   = s_flags_d[i*8 +: 8];
            m_eop_d     = s_eop_d[i*EW +: EW];
            s_data_r[i] = sink_rdy;
         end
      end
   end

   assign s_flags_r = s_data_r;
   assign s_eop_r   = s_data_r;
   assign m_data_v  = busy & req[grant];
   assign m_flags_v = m_data_v;
   assign m_eop_v   = m_data_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         grant      <= '0;
         last_grant <= 2'(NUM_SRC - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant <= nxt_grant;
                  state <= BUSY;
                  busy  <= 1'b1;
               end
            end
            BUSY: begin
               if (xfer && eop_beat) begin
                  last_grant <= grant;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PKTUNIT_ARB_PKT_CNT_EN
   logic [15:0] cnt_q [NUM_SRC];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++)
            cnt_q[i] <= '0;
      end else if (xfer && eop_beat) begin
         for (int i = 0; i < NUM_SRC; i++)
            if (grant == 2'(i) && cnt_q[i] != 16'hFFFF)
               cnt_q[i] <= cnt_q[i] + 16'd1;
      end
   end

   always_comb begin
      pkt_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++)
         pkt_cnt[i*16 +: 16] = cnt_q[i];
   end
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pktunit_axis_arbiter.sv
// Directed plus randomized bench for pktunit_axis_arbiter against a rule-level reference model.
// Expected pkt_cnt follows PKTUNIT_ARB_PKT_CNT_EN.
module tb_pktunit_axis_arbiter;
   localparam int N  = 2;
   localparam int DW = 64;
   localparam int EW = 9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N*DW-1:0]   s_data_d = '0;
   logic [N-1:0]      s_data_v = '0, s_flags_v = '0, s_eop_v = '0;
   logic [N*8-1:0]    s_flags_d = '0;
   logic [N*EW-1:0]   s_eop_d = '0;
   logic [N-1:0]      s_data_r, s_flags_r, s_eop_r;
   logic [DW-1:0]     m_data_d;
   logic [7:0]        m_flags_d;
   logic [EW-1:0]     m_eop_d;
   logic              m_data_v, m_flags_v, m_eop_v;
   logic              m_data_r = 1'b0, m_flags_r = 1'b0, m_eop_r = 1'b0;
   logic [1:0]        grant;
   logic              busy;
   logic [N*16-1:0]   pkt_cnt;

   always #5 clk = ~clk;

   pktunit_axis_arbiter #(.DATA_BYTES(8), .NUM_SRC(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data_d(s_data_d), .s_data_v(s_data_v), .s_flags_v(s_flags_v), .s_eop_v(s_eop_v),
      .s_flags_d(s_flags_d), .s_eop_d(s_eop_d),
      .s_data_r(s_data_r), .s_flags_r(s_flags_r), .s_eop_r(s_eop_r),
      .m_data_d(m_data_d), .m_flags_d(m_flags_d), .m_eop_d(m_eop_d),
      .m_data_v(m_data_v), .m_flags_v(m_flags_v), .m_eop_v(m_eop_v),
      .m_data_r(m_data_r), .m_flags_r(m_flags_r), .m_eop_r(m_eop_r),
      .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   int checks = 0;
   int errors = 0;

   // source generators
   int            rem [N];
   int            pkts_left [N];
   logic [DW-1:0] sd [N];
   logic [7:0]    sf [N];
   logic [EW-1:0] smask [N];
   int            vprob = 100, rprob = 100, sprob = 100, fix_len = 0, stall_data = 0;
   logic [EW-1:0] fix_mask = '0;
   bit            rst_pulse = 1'b0;

   // reference model: owner = -1 means nobody holds the sink
   int owner = -1;
   int last  = N - 1;
   int cnt [N];
   int beat_src [$];
   int busy_cycles = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] cur_eop(input int i);
      return (rem[i] == 1) ? smask[i] : '0;
   endfunction

   function automatic logic [N*16-1:0] exp_cnt();
      logic [N*16-1:0] r = '0;
`ifdef PKTUNIT_ARB_PKT_CNT_EN
      for (int i = 0; i < N; i++) r[i*16 +: 16] = 16'(cnt[i]);
`endif
      return r;
   endfunction

   task automatic new_beat(input int i);
      sd[i] = {$urandom, $urandom};
      sf[i] = 8'($urandom);
   endtask

   task automatic start_pkt(input int i);
      logic [EW-1:0] m;
      rem[i] = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
      m = 9'($urandom);
      if (m == '0) m = 9'h001;
      smask[i] = (fix_mask != '0) ? fix_mask : m;
      new_beat(i);
      if (pkts_left[i] > 0) pkts_left[i]--;
   endtask

   task automatic model_reset();
      owner = -1;
      last  = N - 1;
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0; rem[i] = 0; pkts_left[i] = 0;
      end
   endtask

   // One clock: drive at the negedge, check 1 ns later, advance the model for the next posedge.
   task automatic step();
      logic [N-1:0]  req, exp_r;
      logic [2:0]    rdy;
      logic          all_r, exp_v;
      logic [127:0]  exp_d;
      logic [EW-1:0] e;
      bit            found;
      int            c;
      for (int i = 0; i < N; i++) begin
         if (rem[i] == 0 && pkts_left[i] != 0 && $urandom_range(0, 99) < sprob) start_pkt(i);
         s_data_v[i]  = (rem[i] > 0) && ($urandom_range(0, 99) < vprob);
         s_flags_v[i] = s_data_v[i];
         s_eop_v[i]   = s_data_v[i];
         if (s_data_v[i] && vprob < 100 && $urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
               0: s_data_v[i] = 1'b0;
               1: s_flags_v[i] = 1'b0;
               default: s_eop_v[i] = 1'b0;
            endcase
         end
         s_data_d[i*DW +: DW] = sd[i];
         s_flags_d[i*8 +: 8]  = sf[i];
         s_eop_d[i*EW +: EW]  = cur_eop(i);
      end
      for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 99) < rprob);
      if (stall_data > 0) begin
         rdy[2] = 1'b0;
         stall_data--;
      end
      {m_data_r, m_flags_r, m_eop_r} = rdy;
      #1;
      req   = s_data_v & s_flags_v & s_eop_v;
      all_r = &rdy;
      exp_v = (owner >= 0) && req[owner];
      exp_d = (owner >= 0) ? {sf[owner], cur_eop(owner), sd[owner]} : '0;
      exp_r = (owner >= 0 && all_r) ? N'(1 << owner) : '0;
      chk("busy", busy, owner >= 0);
      if (owner >= 0) chk("grant", grant, 2'(owner));
      chk("m_valid", {m_data_v, m_flags_v, m_eop_v}, {3{exp_v}});
      chk("m_beat", {m_flags_d, m_eop_d, m_data_d}, exp_d);
      chk("s_ready", {s_data_r, s_flags_r, s_eop_r}, {3{exp_r}});
      chk("pkt_cnt", pkt_cnt, exp_cnt());
      for (int i = 0; i < N; i++) if (s_data_r[i] && req[i]) beat_src.push_back(i);
      if (busy) busy_cycles++;
      if (rst_pulse) begin
         #1 rst_n = 1'b0;
         #1;
         chk("rst_busy", busy, 1'b0);
         chk("rst_valid", {m_data_v, m_flags_v, m_eop_v}, 3'b000);
         chk("rst_ready", {s_data_r, s_flags_r, s_eop_r}, '0);
         chk("rst_beat", {m_flags_d, m_eop_d, m_data_d}, '0);
         chk("rst_cnt", pkt_cnt, '0);
         model_reset();
         s_data_v = '0; s_flags_v = '0; s_eop_v = '0;
         rst_pulse = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      if (owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (!found && req[c]) begin
               owner = c;
               found = 1'b1;
            end
         end
      end else if (req[owner] && all_r) begin
         e = cur_eop(owner);
         rem[owner]--;
         if (rem[owner] > 0) new_beat(owner);
         if (e != '0) begin
            last = owner;
            if (cnt[owner] < 65535) cnt[owner]++;
            owner = -1;
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      model_reset();
      #1;
      chk("init_busy", busy, 1'b0);
      chk("init_valid", {m_data_v, m_flags_v, m_eop_v}, 3'b000);
      chk("init_ready", {s_data_r, s_flags_r, s_eop_r}, '0);
      chk("init_grant", grant, 2'd0);
      chk("init_cnt", pkt_cnt, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // both sources start 3-beat packets together: src0 first, then src1, no interleave
      fix_len = 3; fix_mask = 9'h100; pkts_left = '{1, 1};
      beat_src.delete();
      run(12);
      chk("rr_beats", beat_src.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < beat_src.size()) chk("rr_order", beat_src[i], (i < 3) ? 0 : 1);

      // single-beat packet with eop 9'h001 holds the sink for exactly one cycle
      fix_len = 1; fix_mask = 9'h001; pkts_left = '{1, 0};
      beat_src.delete(); busy_cycles = 0;
      run(5);
      chk("single_busy", busy_cycles, 1);
      chk("single_beats", beat_src.size(), 1);

      // sink stalls m_data_r for 4 cycles after the first beat
      fix_len = 4; fix_mask = '0; pkts_left = '{1, 0};
      beat_src.delete();
      run(2);
      stall_data = 4;
      run(10);
      chk("stall_beats", beat_src.size(), 4);

      // reset while beat 2 of a 4-beat packet is on the bus, then fresh requests
      pkts_left = '{1, 0};
      run(2);
      rst_pulse = 1'b1;
      step();
      fix_len = 2; pkts_left = '{1, 1};
      beat_src.delete();
      run(10);
      chk("post_rst_beats", beat_src.size(), 4);
      if (beat_src.size() > 0) chk("post_rst_first", beat_src[0], 0);

      // 2 packets from src0, 5 from src1, counters from a clean reset
      rst_pulse = 1'b1;
      step();
      fix_len = 0; pkts_left = '{2, 5};
      run(60);
`ifdef PKTUNIT_ARB_PKT_CNT_EN
      chk("cnt_5_2", pkt_cnt, {16'd5, 16'd2});
`else
      chk("cnt_off", pkt_cnt, '0);
`endif

      // randomized traffic, sink back-pressure and an occasional reset
      pkts_left = '{-1, -1};
      for (int ph = 0; ph < 6; ph++) begin
         vprob = $urandom_range(50, 100);
         rprob = $urandom_range(40, 100);
         sprob = $urandom_range(20, 100);
         if (ph == 3) begin
            rst_pulse = 1'b1;
            step();
            pkts_left = '{-1, -1};
         end
         run(400);
      end
      chk("final_cnt", pkt_cnt, exp_cnt());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pktunit_axis_arbiter.md
PKTUNIT_AXIS_ARBITER -- requirements
Module: pktunit_axis_arbiter

Interface
REQ-001 Parameter: DATA_BYTES, 8, bytes per packet-unit beat.
REQ-002 Parameter: NUM_SRC, 2, number of requesting sources (legal 2..4).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_data_d  in  NUM_SRC*DATA_BYTES*8  per-source beat data; source i at slice i.
REQ-006 s_data_v, s_flags_v, s_eop_v  in  NUM_SRC each  per-source channel valids.
REQ-007 s_flags_d  in  NUM_SRC*8  per-source flags.
REQ-008 s_eop_d  in  NUM_SRC*(DATA_BYTES+1)  per-source end-of-packet byte mask; nonzero means last beat.
REQ-009 s_data_r, s_flags_r, s_eop_r  out  NUM_SRC each  per-source channel readies.
REQ-010 m_data_d / m_flags_d / m_eop_d  out  DATA_BYTES*8 / 8 / DATA_BYTES+1  granted beat toward the packet-unit sink.
REQ-011 m_data_v, m_flags_v, m_eop_v  out  1 each  beat valid toward the sink.
REQ-012 m_data_r, m_flags_r, m_eop_r  in  1 each  sink readies.
REQ-013 grant  out  2  index of the granted source; meaningful only while busy=1.
REQ-014 busy  out  1  high while a packet is granted (state BUSY).
REQ-015 pkt_cnt  out  NUM_SRC*16  per-source completed-packet counters (see Configuration).

Function
REQ-016 Source i requests when s_data_v[i] & s_flags_v[i] & s_eop_v[i] (joint valid, req[i]).
REQ-017 FSM has two states: IDLE, BUSY.
REQ-018 IDLE: if any req, register grant = first requesting index scanning from (last_grant+1) mod NUM_SRC upward with wrap, go to BUSY; else stay IDLE.
REQ-019 BUSY: m_*_d = granted source's fields; m_data_v = m_flags_v = m_eop_v = req[grant] (three valids always equal).
REQ-020 IDLE: m_*_v = 0; m_*_d = 0.
REQ-021 s_data_r[i] = s_flags_r[i] = s_eop_r[i] = busy & (grant==i) & m_data_r & m_flags_r & m_eop_r; zero for all non-granted sources.
REQ-022 Beat transfer: BUSY & req[grant] & all three m readies high in same cycle.
REQ-023 Transfer with nonzero eop mask ends the packet: last_grant <= grant, state -> IDLE next cycle.
REQ-024 Grant is locked for the whole packet; requests from other sources never preempt.
REQ-025 Latency: first beat can transfer the cycle after request seen in IDLE; one IDLE bubble cycle between packets.
REQ-026 Granted source dropping joint valid mid-packet: stay BUSY, hold grant, m_*_v = 0 until valid returns.
REQ-027 Single-beat packet (eop nonzero on first beat): BUSY exactly one cycle when sink ready.
REQ-028 grant register values >= NUM_SRC are never produced.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, busy 0, grant 0, last_grant NUM_SRC-1 (source 0 first priority), all m_*_v 0, all s_*_r 0, pkt_cnt 0.
REQ-030 Reset mid-packet abandons the packet; no residual beat is emitted after release.
REQ-031 First arbitration occurs on the first rising edge with rst_n high.

Configuration
REQ-032 Macro PKTUNIT_ARB_PKT_CNT_EN defined: pkt_cnt slice i increments by 1 on each end-of-packet transfer from source i, saturating at 16'hFFFF.
REQ-033 Macro undefined: pkt_cnt tied to all-zero, no counter registers; all other behaviour identical.

Verification
REQ-034 NUM_SRC=2; src0 and src1 both request 3-beat packets at same cycle after reset -> src0 granted first, src1 packet follows after one IDLE cycle, no interleaved beats.
REQ-035 src1 streams packets continuously, src0 requests mid src1 packet -> src0 waits until src1 eop beat, then granted next.
REQ-036 Sink deasserts m_data_r for 4 cycles mid packet -> m data held stable, granted s_*_r low those cycles, no beat lost or duplicated.
REQ-037 rst_n asserted during beat 2 of a 4-beat packet -> outputs zero immediately; after release src0 granted on fresh request.
REQ-038 With PKTUNIT_ARB_PKT_CNT_EN: 5 packets from src1, 2 from src0 -> pkt_cnt = {16'd5, 16'd2}; without macro -> pkt_cnt = 0.
REQ-039 Single-beat packet with s_eop_d = 9'h001, sink always ready -> busy high one cycle, transfer occurs cycle after request.
